// File: rtl/speed_test_pkt_gen.sv
// Synthetic Ethernet frame source for the speed tester TX path: header, sequence
// number and incrementing payload on a byte-wide AXI-Stream, with gap pacing and counters.
module speed_test_pkt_gen #(
  parameter int          USER_WIDTH = 1,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [10:0]           frame_len,
  input  logic [15:0]           gap_cycles,
  input  logic [31:0]           frame_limit,
  input  logic [47:0]           dst_mac,
  input  logic [47:0]           src_mac,
  input  logic                  clear,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy,
  output logic [31:0]           tx_frames,
  output logic [47:0]           tx_bytes
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t      state, state_nxt;
  logic        start, last_hs, can_start, rearm;
  logic [10:0] idx, idx_d, idx_inc, len, len_clamp;
  logic [47:0] dst_q, src_q;
  logic [31:0] seq_q, run_count, run_base, run_eff, tx_frames_nxt;
  logic [15:0] gap_cnt;
  logic        tvalid_d, tlast_d;
  logic [7:0]  tdata_d;

  function automatic logic [7:0] byte_at(input logic [10:0] i, input logic [47:0] d,
                                         input logic [47:0] s, input logic [31:0] sq);
    logic [7:0] b;
    case (i)
      11'd0:   b = d[47:40];
      11'd1:   b = d[39:32];
      11'd2:   b = d[31:24];
      11'd3:   b = d[23:16];
      11'd4:   b = d[15:8];
      11'd5:   b = d[7:0];
      11'd6:   b = s[47:40];
      11'd7:   b = s[39:32];
      11'd8:   b = s[31:24];
      11'd9:   b = s[23:16];
      11'd10:  b = s[15:8];
      11'd11:  b = s[7:0];
      11'd12:  b = ETHERTYPE[15:8];
      11'd13:  b = ETHERTYPE[7:0];
      11'd14:  b = sq[31:24];
      11'd15:  b = sq[23:16];
      11'd16:  b = sq[15:8];
      11'd17:  b = sq[7:0];
      default: b = i[7:0] - 8'd18;  // payload counts from zero, wraps mod 256
    endcase
    return b;
  endfunction

  always_comb begin
    len_clamp = frame_len;
    if (frame_len < 11'd60)        len_clamp = 11'd60;
    else if (frame_len > 11'd1514) len_clamp = 11'd1514;
  end

  assign last_hs       = (state == S_SEND) & m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign idx_inc       = idx + 11'd1;
  assign run_base      = run_count + {31'd0, last_hs};
  // A run restarts when enable was seen low in IDLE, so an exhausted limit re-arms.
  assign run_eff       = (state == S_IDLE && rearm) ? 32'd0 : run_base;
  assign can_start     = enable && (frame_limit == 32'd0 || run_eff < frame_limit);
  assign tx_frames_nxt = clear ? 32'd0 : tx_frames + {31'd0, last_hs};
  assign m_axis_tuser  = '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: if (can_start) begin state_nxt = S_SEND; start = 1'b1; end
      S_SEND: if (last_hs) begin
        if (gap_cycles != 16'd0) state_nxt = S_GAP;
        else if (can_start)      start = 1'b1;
        else                     state_nxt = S_IDLE;
      end
      S_GAP: if (gap_cnt <= 16'd1) begin
        if (can_start) begin state_nxt = S_SEND; start = 1'b1; end
        else           state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered stream outputs; byte 0 comes straight from the
  // live dst_mac so it is valid the cycle after the start decision.
  always_comb begin
    tvalid_d = m_axis_tvalid;
    tdata_d  = m_axis_tdata;
    tlast_d  = m_axis_tlast;
    idx_d    = idx;
    if (start) begin
      tvalid_d = 1'b1;
      tdata_d  = dst_mac[47:40];
      tlast_d  = 1'b0;
      idx_d    = 11'd0;
    end else if (last_hs) begin
      tvalid_d = 1'b0;
      tdata_d  = 8'd0;
      tlast_d  = 1'b0;
    end else if (state == S_SEND && m_axis_tvalid && m_axis_tready) begin
      idx_d    = idx_inc;
      tdata_d  = byte_at(idx_inc, dst_q, src_q, seq_q);
      tlast_d  = (idx_inc == len - 11'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'd0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      idx           <= 11'd0;
      len           <= 11'd60;
      dst_q         <= 48'd0;
      src_q         <= 48'd0;
      seq_q         <= 32'd0;
      gap_cnt       <= 16'd0;
      run_count     <= 32'd0;
      rearm         <= 1'b0;
      tx_frames     <= 32'd0;
      tx_bytes      <= 48'd0;
    end else begin
      m_axis_tvalid <= tvalid_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tlast  <= tlast_d;
      busy          <= (state_nxt != S_IDLE);
      idx           <= idx_d;
      rearm         <= (state == S_IDLE) && !enable;
      run_count     <= start ? run_eff : run_base;
      if (start) begin
        len   <= len_clamp;
        dst_q <= dst_mac;
        src_q <= src_mac;
        seq_q <= tx_frames_nxt;
      end
      if (last_hs)              gap_cnt <= gap_cycles;
      else if (state == S_GAP)  gap_cnt <= gap_cnt - 16'd1;
      tx_frames <= tx_frames_nxt;
      if (clear)        tx_bytes <= 48'd0;
      else if (last_hs) tx_bytes <= tx_bytes + {37'd0, len};
    end
  end

endmodule

// File: doc/speed_test_pkt_gen.md
# speed_test_pkt_gen

Synthetic Ethernet frame generator for the speed tester's transmit path. It produces a byte-wide AXI-Stream of complete frames into the transmit side of the GMII/AXIS MAC wrapper. Each frame carries a programmable header, a 32-bit sequence number and an incrementing payload. The MAC adds preamble, padding and FCS. The block applies a programmable inter-frame gap for rate control and keeps frame and byte counters.

## Interface
- USER_WIDTH, 1, width of m_axis_tuser (matches MAC wrapper)
- ETHERTYPE, 16'h88B5, EtherType placed in bytes 12-13
- clk  in  1  single clock domain (MAC clock)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; generate while high
- frame_len  in  11  frame length in bytes, excluding FCS; clamped to 60..1514
- gap_cycles  in  16  idle cycles inserted after each frame
- frame_limit  in  32  frames per run; 0 = unlimited
- dst_mac, src_mac  in  48 each  header addresses, byte 0 = bits [47:40]
- clear  in  1  synchronous one-cycle pulse; zeroes counters
- m_axis_tdata  out  8  frame byte
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready
- m_axis_tlast  out  1  last byte of frame
- m_axis_tuser  out  USER_WIDTH  always 0 (no error)
- busy  out  1  high in SEND or GAP
- tx_frames  out  32  frames completed
- tx_bytes  out  48  sum of completed frame lengths (clamped, excluding FCS)

## Operation
- The FSM has three states: IDLE, SEND and GAP. The byte index idx is 11 bits.
- IDLE -> SEND when enable=1 and (frame_limit==0 or run_count<frame_limit).
  - On this transition, latch the clamped frame_len as len, latch dst_mac, src_mac and tx_frames as seq, and set idx=0.
  - run_count zeroes on every IDLE->SEND transition that follows a cycle with enable=0 in IDLE.
- Byte map in SEND:
  - idx 0-5: dst_mac
  - idx 6-11: src_mac
  - idx 12-13: ETHERTYPE, MSB first
  - idx 14-17: seq, big-endian
  - idx >= 18: byte (idx-18) mod 256
- tlast=1 when idx==len-1.
- A handshake (tvalid & tready) advances idx. On the tlast handshake:
  - tx_frames and run_count increment by 1; tx_bytes increments by len.
  - Next state is GAP if gap_cycles>0; otherwise the start condition is re-evaluated immediately (SEND or IDLE).
- GAP counts exactly gap_cycles cycles (latched at frame end), then re-evaluates the start condition.
- enable deasserted mid-frame: the current frame completes in full, then the block goes to IDLE. It never truncates a frame.
- clear: tx_frames and tx_bytes become 0. If clear coincides with a tlast handshake, clear wins (result 0). An in-flight frame is unaffected.
- Counters wrap modulo 2^width, with no saturation.

## Timing
- All outputs are registered. Reset values: tvalid=0, tdata=0, tlast=0, tuser=0, busy=0, tx_frames=0, tx_bytes=0. The FSM resets to IDLE.
- Reset mid-frame aborts the frame immediately (the MAC underflow path handles this).
- Start latency: enable rises in IDLE at cycle N; tvalid=1 with byte 0 at cycle N+1.
- AXIS rules:
  - Once tvalid=1, tvalid, tdata and tlast are held stable until the handshake.
  - tvalid never drops inside a frame.
  - tvalid does not depend combinationally on tready.
- Throughput is 1 byte/cycle with tready=1. A frame occupies exactly len handshake cycles.
- gap_cycles=0: the first byte of the next frame is valid in the cycle after the tlast handshake, so tvalid stays high continuously.
- gap_cycles=G: tvalid=0 for exactly G cycles between the tlast handshake and the next byte 0.
- Counters update in the cycle after the tlast handshake.

## Test plan
- Reset, then enable=1, frame_len=60, gap=0, limit=1, tready=1.
  - One frame of 60 bytes; bytes 14-17 = 00 00 00 00 and byte 18 = 00; tlast on byte 59.
  - Then IDLE, with tx_frames=1 and tx_bytes=60.
- frame_len=20 and frame_len=2000 -> frames of 60 and 1514 bytes respectively; byte 1513 = (1513-18) mod 256 = 0xD7.
- limit=3, gap=5 -> exactly three frames with seq 0, 1, 2; tvalid low for exactly 5 cycles between frames; tx_bytes=3*len.
- Random tready (50%) -> output equals the tready=1 reference byte stream; data is stable while tvalid=1 and tready=0; tvalid never drops mid-frame.
- Deassert enable at idx 30 of a 100-byte frame -> the frame still completes (100 bytes), then no further tvalid.
  - clear on the tlast handshake cycle -> tx_frames=0 and tx_bytes=0.
- Assert rst_n=0 at idx 40 -> all outputs reset at once.
  - After release with enable=1, the next frame starts at byte 0 with seq equal to 0.
